// File: rtl/control_sequencer_pkg.sv
// Shared opcode, control-word bit index and micro-step definitions for the bus computer.
// The datapath modules decode the control word with the same bit indices.
package control_sequencer_pkg;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam int unsigned CtrlHlt     = 15;
  localparam int unsigned CtrlMi      = 14;
  localparam int unsigned CtrlRi      = 13;
  localparam int unsigned CtrlRo      = 12;
  localparam int unsigned CtrlIo      = 11;
  localparam int unsigned CtrlIi      = 10;
  localparam int unsigned CtrlAi      = 9;
  localparam int unsigned CtrlAo      = 8;
  localparam int unsigned CtrlSumout  = 7;
  localparam int unsigned CtrlSub     = 6;
  localparam int unsigned CtrlBi      = 5;
  localparam int unsigned CtrlOi      = 4;
  localparam int unsigned CtrlCe      = 3;
  localparam int unsigned CtrlCo      = 2;
  localparam int unsigned CtrlJ       = 1;
  localparam int unsigned CtrlFlagsin = 0;

  typedef enum logic [2:0] {
    StT0 = 3'd0,
    StT1 = 3'd1,
    StT2 = 3'd2,
    StT3 = 3'd3,
    StT4 = 3'd4
  } step_e;

  function automatic logic [15:0] cbit(input int unsigned idx);
    cbit = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/control_sequencer_rom.sv
// Combinational microcode: (opcode, step, flags) -> 16-bit control word.
// Fetch words are shared by all opcodes; unlisted execute steps are all-zero.
module microcode_rom
  import control_sequencer_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [2:0]  step,
  input  logic        carryflg,
  input  logic        zeroflg,
  output logic [15:0] word
);

  step_e st;
  assign st = step_e'(step);

  always_comb begin
    word = '0;
    case (st)
      StT0: word = cbit(CtrlCo) | cbit(CtrlMi);
      StT1: word = cbit(CtrlRo) | cbit(CtrlIi) | cbit(CtrlCe);
      default: begin
        case (opcode)
          OpLda: begin
            if (st == StT2)      word = cbit(CtrlIo) | cbit(CtrlMi);
            else if (st == StT3) word = cbit(CtrlRo) | cbit(CtrlAi);
          end
          OpAdd, OpSub: begin
            if (st == StT2)      word = cbit(CtrlIo) | cbit(CtrlMi);
            else if (st == StT3) word = cbit(CtrlRo) | cbit(CtrlBi);
            else if (st == StT4) begin
              word = cbit(CtrlSumout) | cbit(CtrlAi) | cbit(CtrlFlagsin);
              if (opcode == OpSub) word = word | cbit(CtrlSub);
            end
          end
          OpSta: begin
            if (st == StT2)      word = cbit(CtrlIo) | cbit(CtrlMi);
            else if (st == StT3) word = cbit(CtrlAo) | cbit(CtrlRi);
          end
          OpLdi: if (st == StT2) word = cbit(CtrlIo) | cbit(CtrlAi);
          OpJmp: if (st == StT2) word = cbit(CtrlIo) | cbit(CtrlJ);
          OpJc:  if (st == StT2 && carryflg) word = cbit(CtrlIo) | cbit(CtrlJ);
          OpJz:  if (st == StT2 && zeroflg)  word = cbit(CtrlIo) | cbit(CtrlJ);
          OpOut: if (st == StT2) word = cbit(CtrlAo) | cbit(CtrlOi);
          OpHlt: if (st == StT2) word = cbit(CtrlHlt);
          default: word = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step counter, halt register and halt masking around the microcode ROM.
// Define STEP_SKIP_EN to return to T0 early when the remaining execute words are empty.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  opcode,
  input  logic        carryflg,
  input  logic        zeroflg,
  output logic [15:0] ctrl,
  output logic [2:0]  step
);

  step_e       step_q;
  step_e       step_next;
  logic        halted_q;
  logic [15:0] word;
  logic        skip;

  microcode_rom u_rom (
    .opcode   (opcode),
    .step     (step_q),
    .carryflg (carryflg),
    .zeroflg  (zeroflg),
    .word     (word)
  );

  always_comb begin
    if (step_q == StT4) step_next = StT0;
    else                step_next = step_e'(step_q + 3'd1);
  end

`ifdef STEP_SKIP_EN
  logic [15:0] word_ahead;

  // Look one step ahead: an empty next word means the instruction is done now.
  microcode_rom u_rom_ahead (
    .opcode   (opcode),
    .step     (step_next),
    .carryflg (carryflg),
    .zeroflg  (zeroflg),
    .word     (word_ahead)
  );

  assign skip = (step_q == StT2 || step_q == StT3) && (word_ahead == '0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      step_q   <= StT0;
      halted_q <= 1'b0;
    end else if (halted_q) begin
      step_q   <= step_q;
    end else if (word[CtrlHlt]) begin
      // Freeze at T2 so the halted step stays visible.
      halted_q <= 1'b1;
    end else if (skip) begin
      step_q   <= StT0;
    end else begin
      step_q   <= step_next;
    end
  end

  assign ctrl = halted_q ? cbit(CtrlHlt) : word;
  assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; expected words built from the control-word bit layout
// {hlt,mi,ri,ro,io,ii,ai,ao,sumout,sub,bi,oi,ce,co,j,flagsin}.
module tb_control_sequencer;

  logic        clk;
  logic        clr;
  logic [3:0]  opcode;
  logic        carryflg;
  logic        zeroflg;
  logic [15:0] ctrl;
  logic [2:0]  step;

  int checks;
  int failures;

  control_sequencer dut (
    .clk      (clk),
    .clr      (clr),
    .opcode   (opcode),
    .carryflg (carryflg),
    .zeroflg  (zeroflg),
    .ctrl     (ctrl),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s ctrl observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s step observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one instruction from T0 and ends at T0 of the next, checking every step.
  task automatic do_instr(input string tag, input logic [3:0] op,
                          input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
    opcode = op;
    chk16({tag, "_t0"}, ctrl, 16'h4004);
    chk3({tag, "_t0"}, step, 3'd0);
    tick();
    chk16({tag, "_t1"}, ctrl, 16'h1408);
    chk3({tag, "_t1"}, step, 3'd1);
    tick();
    chk16({tag, "_t2"}, ctrl, w2);
    chk3({tag, "_t2"}, step, 3'd2);
    tick();
`ifdef STEP_SKIP_EN
    if (w3 == 16'h0000) begin
      chk3({tag, "_wrap"}, step, 3'd0);
      return;
    end
`endif
    chk16({tag, "_t3"}, ctrl, w3);
    chk3({tag, "_t3"}, step, 3'd3);
    tick();
`ifdef STEP_SKIP_EN
    if (w4 == 16'h0000) begin
      chk3({tag, "_wrap"}, step, 3'd0);
      return;
    end
`endif
    chk16({tag, "_t4"}, ctrl, w4);
    chk3({tag, "_t4"}, step, 3'd4);
    tick();
    chk3({tag, "_wrap"}, step, 3'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b1;
    opcode   = 4'h0;
    carryflg = 1'b0;
    zeroflg  = 1'b0;
    tick();
    clr = 1'b0;
    chk16("reset", ctrl, 16'h4004);
    chk3("reset", step, 3'd0);

    do_instr("add", 4'h2, 16'h4800, 16'h1020, 16'h0281);
    do_instr("sub", 4'h3, 16'h4800, 16'h1020, 16'h02C1);
    do_instr("lda", 4'h1, 16'h4800, 16'h1200, 16'h0000);
    do_instr("sta", 4'h4, 16'h4800, 16'h2100, 16'h0000);
    do_instr("ldi", 4'h5, 16'h0A00, 16'h0000, 16'h0000);
    do_instr("nop", 4'h0, 16'h0000, 16'h0000, 16'h0000);
    do_instr("jmp", 4'h6, 16'h0802, 16'h0000, 16'h0000);
    do_instr("out", 4'hE, 16'h0110, 16'h0000, 16'h0000);
    do_instr("op_a", 4'hA, 16'h0000, 16'h0000, 16'h0000);

    carryflg = 1'b0;
    do_instr("jc_c0", 4'h7, 16'h0000, 16'h0000, 16'h0000);
    carryflg = 1'b1;
    do_instr("jc_c1", 4'h7, 16'h0802, 16'h0000, 16'h0000);
    carryflg = 1'b0;
    zeroflg  = 1'b0;
    do_instr("jz_z0", 4'h8, 16'h0000, 16'h0000, 16'h0000);
    zeroflg  = 1'b1;
    do_instr("jz_z1", 4'h8, 16'h0802, 16'h0000, 16'h0000);
    zeroflg  = 1'b0;
    // Carry flag set must not leak into JZ.
    carryflg = 1'b1;
    do_instr("jz_c1", 4'h8, 16'h0000, 16'h0000, 16'h0000);
    carryflg = 1'b0;

    // Flag change within JC T2 takes effect combinationally.
    opcode = 4'h7;
    tick();
    tick();
    chk16("jc_live_lo", ctrl, 16'h0000);
    carryflg = 1'b1;
    #1;
    chk16("jc_live_hi", ctrl, 16'h0802);
    carryflg = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk3("jc_live_clr", step, 3'd0);

    // Halt holds step 2 and ctrl=hlt regardless of flags or opcode.
    opcode = 4'hF;
    chk16("hlt_t0", ctrl, 16'h4004);
    tick();
    chk16("hlt_t1", ctrl, 16'h1408);
    tick();
    chk16("hlt_t2", ctrl, 16'h8000);
    chk3("hlt_t2", step, 3'd2);
    tick();
    for (int i = 0; i < 20; i++) begin
      carryflg = i[0];
      zeroflg  = i[1];
      opcode   = 4'h7 + 4'(i[0]);
      #1;
      chk16("halted", ctrl, 16'h8000);
      chk3("halted", step, 3'd2);
      tick();
    end
    carryflg = 1'b0;
    zeroflg  = 1'b0;
    opcode   = 4'h0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk16("hlt_clr", ctrl, 16'h4004);
    chk3("hlt_clr", step, 3'd0);

    // Clear during LDA T3 aborts with no T4.
    opcode = 4'h1;
    tick();
    tick();
    tick();
    chk16("lda_t3", ctrl, 16'h1200);
    chk3("lda_t3", step, 3'd3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk16("lda_abort", ctrl, 16'h4004);
    chk3("lda_abort", step, 3'd0);
    tick();
    chk16("lda_abort_t1", ctrl, 16'h1408);
    chk3("lda_abort_t1", step, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
